mechine: RTL and testbench
==========================

Name: mechine

Overview:
- Keypad-driven controller for a coin-operated phone-charging kiosk.
- The user presses START, types an amount (0–99, decimal), and confirms with ENTER.
- The block then shows the amount and a remaining-charge time of 2 time units per unit of money, and counts that time down to zero.
- It sits between the keypad scanner, which supplies a key strobe and decoded key lines, and the display drivers, which receive money and restime as binary values.

Parameters:
- TICK_CYCLES, 16: CLK cycles per one-unit decrement of restime during charging (must be ≥1).

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- startSet  input  1  key strobe from the keypad scanner; high while a key is held.
- num  input  5  digit value; valid 0–9.
- start  input  1  START key line.
- clear  input  1  CLEAR key line.
- enter  input  1  ENTER/CONFIRM key line.
- money  output  8  entered amount, binary 0–99.
- restime  output  8  remaining charge time, binary 0–198.

Behaviour:
- Every output and register is driven by flops; there is no combinational path from input to output.
- Reset, when sampled high:
  - state=IDLE; money=0; restime=0; tick counter=0.
  - The startSet history register is cleared.
  - Reset has priority over every other event.
- Key event:
  - Register the previous value of startSet.
  - An event occurs on the first CLK edge where startSet=1 and the previous value=0.
  - Holding startSet for many cycles yields exactly one event.
  - The event's effect is visible on money/restime right after that same edge (1-cycle latency).
- Key decode at an event, priority start > clear > enter > digit:
  - A digit event requires start=clear=enter=0 and num≤9.
  - num≥10 with no command line asserted is ignored.
- States and transitions:
  - IDLE:
    - START goes to INPUT with money=0 and restime=0.
    - All other keys are ignored; outputs stay 0.
  - INPUT:
    - Digit d: money ← (money mod 10)*10 + d, so only the last two digits are kept. Example: keys 1,0,7 give 1, 10, 7.
    - restime ← 2*new money on every digit (preview).
    - CLEAR: money=0, restime=0, stay in INPUT.
    - START: same as CLEAR.
    - ENTER with money>0: go to CHARGE, tick counter=0.
    - ENTER with money=0: go to IDLE.
  - CHARGE:
    - All keys are ignored, including START.
    - money holds its value.
    - The tick counter increments each cycle. When it reaches TICK_CYCLES-1, it wraps to 0 and restime decrements by 1.
    - On the cycle restime reaches 0: go to IDLE and money=0.
    - restime never underflows.
- Simultaneous events: a key event arriving on the same edge as a tick in CHARGE is ignored; the tick proceeds.
- Reset mid-charge aborts immediately to IDLE with zeroed outputs.
- No arithmetic overflow is possible: the maximum restime is 198, which fits in 8 bits.

Test Plan:
- Reset, then press '3' while IDLE -> money=0, restime=0.
- START, '1', '5' -> money=15, restime=30. Then CLEAR -> money=0, restime=0.
- '2', '4', ENTER -> money=24, restime=48 at ENTER.
  - restime then decrements by 1 every TICK_CYCLES clocks.
  - After 48*TICK_CYCLES clocks: money=0, restime=0, IDLE.
- During CHARGE press '3' and START -> money/restime are unaffected and the countdown continues.
- From IDLE: START, '1', '0', '7' -> money goes 1, 10, 7 and restime goes 2, 20, 14. Then CLEAR -> 0, 0. Then ENTER -> IDLE.
- Hold startSet high for 10 cycles with num=5 in INPUT -> a single digit event, money=5, not 55.
- Assert reset mid-CHARGE -> next cycle money=0, restime=0, and keys other than START are ignored.

Source files
------------

// File: rtl/mechine.sv
// Kiosk keypad controller: keys set the amount, then restime counts down; results visible 1 cycle after the key edge.
// No backpressure: keys are edge-detected one-shots and are dropped outside IDLE/INPUT handling.
module mechine #(
  parameter int TICK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       startSet,
  input  logic [4:0] num,
  input  logic       start,
  input  logic       clear,
  input  logic       enter,
  output logic [7:0] money,
  output logic [7:0] restime
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INPUT  = 2'd1,
    CHARGE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    money_nxt, restime_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic          set_q;
  logic          key_evt;
  logic          is_digit;
  logic [7:0]    digit_money;

  assign key_evt     = startSet & ~set_q;
  assign is_digit    = ~start & ~clear & ~enter & (num <= 5'd9);
  // Keep only the last two typed digits.
  assign digit_money = (money % 8'd10) * 8'd10 + {3'b000, num};

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      money    <= 8'd0;
      restime  <= 8'd0;
      tick_cnt <= '0;
      set_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      money    <= money_nxt;
      restime  <= restime_nxt;
      tick_cnt <= tick_nxt;
      set_q    <= startSet;
    end
  end

  always_comb begin
    state_nxt   = state;
    money_nxt   = money;
    restime_nxt = restime;
    tick_nxt    = tick_cnt;
    case (state)
      IDLE: begin
        if (key_evt && start) begin
          state_nxt   = INPUT;
          money_nxt   = 8'd0;
          restime_nxt = 8'd0;
        end
      end
      INPUT: begin
        if (key_evt) begin
          if (start || clear) begin
            money_nxt   = 8'd0;
            restime_nxt = 8'd0;
          end else if (enter) begin
            if (money != 8'd0) begin
              state_nxt = CHARGE;
              tick_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else if (is_digit) begin
            money_nxt   = digit_money;
            restime_nxt = {digit_money[6:0], 1'b0};
          end
        end
      end
      CHARGE: begin
        // Keys are ignored here, so a key landing on a tick edge cannot disturb it.
        if (restime == 8'd0) begin
          state_nxt = IDLE;
          money_nxt = 8'd0;
          tick_nxt  = '0;
        end else if (tick_cnt == TICK_LAST) begin
          tick_nxt    = '0;
          restime_nxt = restime - 8'd1;
          if (restime == 8'd1) begin
            state_nxt = IDLE;
            money_nxt = 8'd0;
          end
        end else begin
          tick_nxt = tick_cnt + TW'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        money_nxt   = 8'd0;
        restime_nxt = 8'd0;
        tick_nxt    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mechine.sv
// Directed, table-driven bench for the kiosk keypad controller.
module tb_mechine;

  localparam int T = 16;

  logic       CLK = 1'b0;
  logic       reset;
  logic       startSet;
  logic [4:0] num;
  logic       start;
  logic       clear;
  logic       enter;
  logic [7:0] money;
  logic [7:0] restime;

  int total = 0;
  int bad   = 0;

  mechine #(.TICK_CYCLES(T)) dut (
    .CLK(CLK), .reset(reset), .startSet(startSet), .num(num),
    .start(start), .clear(clear), .enter(enter),
    .money(money), .restime(restime)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       st;
    logic       cl;
    logic       en;
    logic [4:0] n;
    logic [7:0] em;
    logic [7:0] er;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [7:0] em, input logic [7:0] er);
    total++;
    if (money !== em || restime !== er) begin
      bad++;
      $display("FAIL %s: money=%0d restime=%0d expected money=%0d restime=%0d",
               name, money, restime, em, er);
    end
  endtask

  // One key stroke: strobe high for one cycle, released before the next.
  task automatic press(input logic s, input logic c, input logic e, input logic [4:0] n);
    @(negedge CLK);
    startSet = 1'b1; start = s; clear = c; enter = e; num = n;
    @(negedge CLK);
    startSet = 1'b0; start = 1'b0; clear = 1'b0; enter = 1'b0; num = 5'd0;
  endtask

  initial begin
    reset = 1'b1; startSet = 1'b0; num = 5'd0;
    start = 1'b0; clear = 1'b0; enter = 1'b0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 5'd3,  8'd0,  8'd0};  // digit in IDLE
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'd0,  8'd0,  8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'd0,  8'd0,  8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'd0,  8'd0,  8'd0};  // -> INPUT
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd1,  8'd1,  8'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'd5,  8'd15, 8'd30};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 5'd12, 8'd15, 8'd30}; // invalid digit
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'd0,  8'd0,  8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 5'd1,  8'd1,  8'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  8'd10, 8'd20};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 5'd7,  8'd7,  8'd14};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'd0,  8'd0,  8'd0};  // START acts as CLEAR
    tbl[12] = '{1'b0, 1'b0, 1'b0, 5'd9,  8'd9,  8'd18};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 5'd4,  8'd0,  8'd0};  // start beats digit
    tbl[14] = '{1'b0, 1'b0, 1'b0, 5'd2,  8'd2,  8'd4};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 5'd0,  8'd0,  8'd0};  // clear beats enter
    tbl[16] = '{1'b0, 1'b0, 1'b0, 5'd6,  8'd6,  8'd12};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 5'd0,  8'd0,  8'd0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 5'd0,  8'd0,  8'd0};  // enter with 0 -> IDLE
    tbl[19] = '{1'b0, 1'b0, 1'b0, 5'd4,  8'd0,  8'd0};  // ignored in IDLE

    repeat (3) @(negedge CLK);
    chk("reset_state", 8'd0, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      press(tbl[i].st, tbl[i].cl, tbl[i].en, tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].em, tbl[i].er);
    end

    // Held strobe gives a single digit event.
    press(1'b1, 1'b0, 1'b0, 5'd0);
    chk("start_again", 8'd0, 8'd0);
    @(negedge CLK);
    startSet = 1'b1; num = 5'd5;
    repeat (10) @(negedge CLK);
    startSet = 1'b0; num = 5'd0;
    @(negedge CLK);
    chk("hold_single", 8'd5, 8'd10);

    press(1'b0, 1'b1, 1'b0, 5'd0);
    press(1'b0, 1'b0, 1'b0, 5'd2);
    chk("dig_2", 8'd2, 8'd4);
    press(1'b0, 1'b0, 1'b0, 5'd4);
    chk("dig_24", 8'd24, 8'd48);

    // ENTER: event edge is the posedge just before this negedge.
    @(negedge CLK);
    startSet = 1'b1; enter = 1'b1;
    @(negedge CLK);
    startSet = 1'b0; enter = 1'b0;
    chk("enter", 8'd24, 8'd48);
    for (int j = 1; j <= 48 * T; j++) begin
      // Stray keys during charge, including one whose edge coincides with a tick.
      if (j == 100) begin startSet = 1'b1; num = 5'd3; end
      if (j == 102) begin startSet = 1'b0; num = 5'd0; end
      if (j == 207) begin startSet = 1'b1; start = 1'b1; end
      if (j == 210) begin startSet = 1'b0; start = 1'b0; end
      @(negedge CLK);
      if (j % 8 == 0 || j % T == T - 1 || (j >= 100 && j <= 104) || (j >= 207 && j <= 211))
        chk($sformatf("charge_j%0d", j), (j == 48 * T) ? 8'd0 : 8'd24, 8'(48 - j / T));
    end
    repeat (3) @(negedge CLK);
    chk("charge_done", 8'd0, 8'd0);

    press(1'b0, 1'b0, 1'b0, 5'd3);
    chk("idle_after_charge", 8'd0, 8'd0);
    press(1'b1, 1'b0, 1'b0, 5'd0);
    press(1'b0, 1'b0, 1'b0, 5'd7);
    chk("dig_7", 8'd7, 8'd14);

    // Reset aborts a charge.
    @(negedge CLK);
    startSet = 1'b1; enter = 1'b1;
    @(negedge CLK);
    startSet = 1'b0; enter = 1'b0;
    repeat (20) @(negedge CLK);
    chk("mid_charge", 8'd7, 8'd13);
    reset = 1'b1;
    @(negedge CLK);
    chk("reset_abort", 8'd0, 8'd0);
    reset = 1'b0;
    press(1'b0, 1'b0, 1'b0, 5'd3);
    chk("post_reset_dig", 8'd0, 8'd0);
    press(1'b0, 1'b1, 1'b0, 5'd0);
    press(1'b0, 1'b0, 1'b1, 5'd0);
    press(1'b0, 1'b0, 1'b0, 5'd5);
    chk("post_reset_keys", 8'd0, 8'd0);
    press(1'b1, 1'b0, 1'b0, 5'd0);
    press(1'b0, 1'b0, 1'b0, 5'd8);
    chk("post_reset_start", 8'd8, 8'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
